exception_unit: RTL and testbench
=================================

# exception_unit

Parametrised, pipelined exception/interrupt controller for the multi-issue MIPS core, sitting at the memory/commit boundary in place of the single-cycle exception decoder. It prioritises exceptions across ISSUE_WIDTH commit slots (slot 0 oldest), kills the faulting slot and all younger ones in the same cycle, and writes CP0 one cycle later. It then sequences a fixed-length pipeline flush and hands the redirect PC to fetch over a valid/ready handshake.

## Interface
- ISSUE_WIDTH, 2: number of commit slots; must be at least 1.
- FLUSH_CYCLES, 2: number of cycles spent in FLUSH; must be at least 1.
- EXC_VECTOR, 32'hbfc00380: general exception entry PC.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- inst_valid, iaddr_alignment_error, daddr_alignment_error, invalid_instruction, priv_instruction, syscall, break_, eret, overflow, mem_wen, is_branch_slot  input  [ISSUE_WIDTH-1:0]  per-slot flags.
- pc_address, mem_address  input  [ISSUE_WIDTH-1:0][31:0]  per-slot PC and data address.
- epc_address  input  32  current CP0 EPC, used as the eret target.
- allow_interrupt  input  1  CP0 Status.IE && !EXL.
- interrupt_flag  input  8  raw Cause.IP && Status.IM lines.
- is_inst  input  1  slot 0 holds a real, interruptible instruction.
- exp_detect  output  1  combinational: an exception or eret was accepted this cycle.
- exp_kill_mask  output  [ISSUE_WIDTH-1:0]  combinational: bits k..ISSUE_WIDTH-1 set, where k is the winning slot.
- cp0_exp_en, cp0_exl_clean, cp0_exp_bad_vaddr_wen, cp0_exp_bd  output  1  registered one-cycle pulses or qualifiers.
- cp0_exp_code  output  5  registered.
- cp0_exp_epc, cp0_exp_bad_vaddr  output  32  registered.
- redirect_valid  output  1  redirect request to fetch.
- redirect_pc  output  32  redirect target.
- redirect_ready  input  1  fetch accepts the redirect.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- Per-slot priority, highest first:
  - interrupt (slot 0 only): inst_valid[0] && is_inst && allow_interrupt && pending != 0 → code 0x00;
  - iaddr → 0x04, bad_vaddr = pc;
  - syscall → 0x08; break_ → 0x09; invalid → 0x0a; priv → 0x0b; overflow → 0x0c;
  - eret;
  - daddr → 0x05 if mem_wen else 0x04, bad_vaddr = mem_address.
- A slot is considered only if its inst_valid bit is set.
- Winner is the lowest-index slot with any hit. Higher slots are ignored.
- EPC and BD: if is_branch_slot[k], epc = pc - 4 (mod 2^32) and bd = 1; otherwise epc = pc and bd = 0.
- Exception winner: cp0_exp_en = 1, redirect_pc = EXC_VECTOR.
- eret winner: cp0_exp_en = 0, cp0_exl_clean = 1, code = 0, redirect_pc = epc_address sampled in the detect cycle.
- State machine:
  - IDLE → FLUSH on exp_detect; the flush counter loads FLUSH_CYCLES-1.
  - FLUSH: counter decrements each cycle; at 0 → REDIRECT.
  - REDIRECT: redirect_valid held high; redirect_pc stable; redirect_ready → IDLE.
- When busy, exp_detect = 0, exp_kill_mask = 0, and all slot inputs are ignored.
- A second exception arriving while busy is therefore dropped. The flushed pipeline guarantees none is legal.

## Timing
- Cycle T (IDLE): exp_detect and kill mask are valid combinationally.
- Cycle T+1: cp0_* registered outputs valid and pulsed for exactly 1 cycle; state is FLUSH.
- Cycle T+1+FLUSH_CYCLES: redirect_valid rises.
- Minimum detect-to-IDLE time is FLUSH_CYCLES+2 cycles, reached when redirect_ready is already high.
- redirect_valid must not drop before redirect_ready. redirect_pc must not change while redirect_valid is high.
- Reset values: every output 0, state IDLE, counter 0, interrupt synchroniser 0.
- Reset asserted mid-sequence aborts immediately to IDLE; no redirect is issued.
- cp0_exp_bad_vaddr is 0 and cp0_exp_bad_vaddr_wen is 0 for codes other than 0x04/0x05.

## Configuration
- EXC_INT_SYNC_EN defined: pending is interrupt_flag passed through a 2-flop synchroniser (+2 cycles interrupt latency). Pending stays 0 for the first 2 cycles after reset.
- EXC_INT_SYNC_EN undefined: pending = interrupt_flag, combinational.

## Structure
- exception_pkg:
  - exc_code_t enum: INT=0x00, ADEL=0x04, ADES=0x05, SYS=0x08, BP=0x09, RI=0x0a, CPU=0x0b, OV=0x0c;
  - exc_state_t enum: IDLE, FLUSH, REDIRECT;
  - slot result struct: hit, is_eret, code, epc, bd, bad_vaddr, bad_vaddr_wen.
- Sub-module exception_slot_decode: combinational per-slot priority encoder, instantiated ISSUE_WIDTH times. The top-level holds slot arbitration, registers and the FSM.

## Test plan
- Slot 1 overflow, pc 0x80001000, slot 0 clean → exp_kill_mask = 2'b10; at T+1 code 0x0c, epc 0x80001000, cp0_exp_en pulse; redirect to 0xbfc00380 at T+3.
- Slot 0 syscall with slot 1 break_ in the same cycle → code 0x08, mask 2'b11.
- Slot 0 store daddr error in a delay slot, pc 0x80000104, addr 0x1002 → code 0x05, epc 0x80000100, bd 1, bad_vaddr 0x1002.
- Slot 0 eret, epc_address 0x80002000 → cp0_exl_clean pulse, cp0_exp_en 0, redirect_pc 0x80002000.
- redirect_ready held low 5 cycles → redirect_valid and redirect_pc stable; a slot-0 syscall during busy is ignored (exp_detect 0).
- interrupt_flag = 0x04, allow_interrupt = 1, is_inst = 1 → code 0x00 at T+1 without EXC_INT_SYNC_EN, at T+3 with it.
- rst asserted during FLUSH → IDLE, redirect_valid never rises.

Source files
------------

// File: rtl/exception_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exception_pkg
// Brief    : Shared types for the commit-stage exception controller.
// Revision : 1.0 - initial release
// ============================================================================
package exception_pkg;

    typedef enum logic [4:0] {
        INT  = 5'h00,
        ADEL = 5'h04,
        ADES = 5'h05,
        SYS  = 5'h08,
        BP   = 5'h09,
        RI   = 5'h0a,
        CPU  = 5'h0b,
        OV   = 5'h0c
    } exc_code_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } exc_state_t;

    typedef struct packed {
        logic        hit;
        logic        is_eret;
        exc_code_t   code;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] bad_vaddr;
        logic        bad_vaddr_wen;
    } slot_result_t;

    // A faulting delay-slot instruction restarts at its branch.
    function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic in_delay_slot);
        return in_delay_slot ? (pc - 32'd4) : pc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exception_slot_decode.sv
`default_nettype none
// ============================================================================
// Module   : exception_slot_decode
// Brief    : Combinational priority encoder for one commit slot.
// Revision : 1.0 - initial release
// ============================================================================
module exception_slot_decode
    import exception_pkg::*;
(
    input  logic         valid,
    input  logic         int_req,
    input  logic         iaddr_alignment_error,
    input  logic         daddr_alignment_error,
    input  logic         invalid_instruction,
    input  logic         priv_instruction,
    input  logic         syscall,
    input  logic         break_,
    input  logic         eret,
    input  logic         overflow,
    input  logic         mem_wen,
    input  logic         is_branch_slot,
    input  logic [31:0]  pc_address,
    input  logic [31:0]  mem_address,
    output slot_result_t result
);

    always_comb begin
        result     = '0;
        result.epc = restart_pc(pc_address, is_branch_slot);
        result.bd  = is_branch_slot;
        if (valid) begin
            result.hit = 1'b1;
            if (int_req) begin
                result.code = INT;
            end else if (iaddr_alignment_error) begin
                result.code          = ADEL;
                result.bad_vaddr     = pc_address;
                result.bad_vaddr_wen = 1'b1;
            end else if (syscall) begin
                result.code = SYS;
            end else if (break_) begin
                result.code = BP;
            end else if (invalid_instruction) begin
                result.code = RI;
            end else if (priv_instruction) begin
                result.code = CPU;
            end else if (overflow) begin
                result.code = OV;
            end else if (eret) begin
                result.is_eret = 1'b1;
            end else if (daddr_alignment_error) begin
                result.code          = mem_wen ? ADES : ADEL;
                result.bad_vaddr     = mem_address;
                result.bad_vaddr_wen = 1'b1;
            end else begin
                result.hit = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/exception_unit.sv
`default_nettype none
// ============================================================================
// Module   : exception_unit
// Brief    : Multi-slot exception/interrupt controller: arbitration, CP0
//            write-back, pipeline flush sequencing and fetch redirect.
//            Define EXC_INT_SYNC_EN to add a 2-flop interrupt synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module exception_unit
    import exception_pkg::*;
#(
    parameter int          ISSUE_WIDTH  = 2,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ISSUE_WIDTH-1:0]      inst_valid,
    input  logic [ISSUE_WIDTH-1:0]      iaddr_alignment_error,
    input  logic [ISSUE_WIDTH-1:0]      daddr_alignment_error,
    input  logic [ISSUE_WIDTH-1:0]      invalid_instruction,
    input  logic [ISSUE_WIDTH-1:0]      priv_instruction,
    input  logic [ISSUE_WIDTH-1:0]      syscall,
    input  logic [ISSUE_WIDTH-1:0]      break_,
    input  logic [ISSUE_WIDTH-1:0]      eret,
    input  logic [ISSUE_WIDTH-1:0]      overflow,
    input  logic [ISSUE_WIDTH-1:0]      mem_wen,
    input  logic [ISSUE_WIDTH-1:0]      is_branch_slot,
    input  logic [ISSUE_WIDTH-1:0][31:0] pc_address,
    input  logic [ISSUE_WIDTH-1:0][31:0] mem_address,
    input  logic [31:0]                 epc_address,
    input  logic                        allow_interrupt,
    input  logic [7:0]                  interrupt_flag,
    input  logic                        is_inst,
    output logic                        exp_detect,
    output logic [ISSUE_WIDTH-1:0]      exp_kill_mask,
    output logic                        cp0_exp_en,
    output logic                        cp0_exl_clean,
    output logic                        cp0_exp_bad_vaddr_wen,
    output logic                        cp0_exp_bd,
    output logic [4:0]                  cp0_exp_code,
    output logic [31:0]                 cp0_exp_epc,
    output logic [31:0]                 cp0_exp_bad_vaddr,
    output logic                        redirect_valid,
    output logic [31:0]                 redirect_pc,
    input  logic                        redirect_ready,
    output logic                        busy
);

    localparam int                 c_CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(FLUSH_CYCLES - 1);

    exc_state_t         r_state;
    exc_state_t         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;

    logic [7:0]             w_pending;
    logic                   w_int_req;
    slot_result_t           w_slot [ISSUE_WIDTH];
    slot_result_t           w_win;
    logic                   w_any_hit;
    logic [ISSUE_WIDTH-1:0] w_mask_raw;
    logic                   w_detect;

    logic        r_cp0_exp_en;
    logic        r_cp0_exl_clean;
    logic        r_cp0_bad_vaddr_wen;
    logic        r_cp0_bd;
    exc_code_t   r_cp0_code;
    logic [31:0] r_cp0_epc;
    logic [31:0] r_cp0_bad_vaddr;
    logic [31:0] r_redirect_pc;

`ifdef EXC_INT_SYNC_EN
    logic [7:0] r_int_sync1;
    logic [7:0] r_int_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int_sync1 <= '0;
            r_int_sync2 <= '0;
        end else begin
            r_int_sync1 <= interrupt_flag;
            r_int_sync2 <= r_int_sync1;
        end
    end

    assign w_pending = r_int_sync2;
`else
    assign w_pending = interrupt_flag;
`endif

    assign w_int_req = is_inst && allow_interrupt && (w_pending != 8'd0);

    // Interrupts are only taken on the oldest slot.
    generate
        for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_slot
            exception_slot_decode u_decode (
                .valid                 (inst_valid[g]),
                .int_req               ((g == 0) ? w_int_req : 1'b0),
                .iaddr_alignment_error (iaddr_alignment_error[g]),
                .daddr_alignment_error (daddr_alignment_error[g]),
                .invalid_instruction   (invalid_instruction[g]),
                .priv_instruction      (priv_instruction[g]),
                .syscall               (syscall[g]),
                .break_                (break_[g]),
                .eret                  (eret[g]),
                .overflow              (overflow[g]),
                .mem_wen               (mem_wen[g]),
                .is_branch_slot        (is_branch_slot[g]),
                .pc_address            (pc_address[g]),
                .mem_address           (mem_address[g]),
                .result                (w_slot[g])
            );
        end
    endgenerate

    // Oldest hitting slot wins; the kill mask covers it and every younger slot.
    always_comb begin
        w_win      = '0;
        w_any_hit  = 1'b0;
        w_mask_raw = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (w_slot[i].hit && !w_any_hit) begin
                w_win     = w_slot[i];
                w_any_hit = 1'b1;
            end
            w_mask_raw[i] = w_any_hit;
        end
    end

    assign w_detect      = (r_state == IDLE) && w_any_hit;
    assign exp_detect    = w_detect;
    assign exp_kill_mask = w_detect ? w_mask_raw : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cp0_exp_en        <= 1'b0;
            r_cp0_exl_clean     <= 1'b0;
            r_cp0_bad_vaddr_wen <= 1'b0;
            r_cp0_bd            <= 1'b0;
            r_cp0_code          <= INT;
            r_cp0_epc           <= '0;
            r_cp0_bad_vaddr     <= '0;
            r_redirect_pc       <= '0;
        end else begin
            r_cp0_exp_en        <= w_detect && !w_win.is_eret;
            r_cp0_exl_clean     <= w_detect && w_win.is_eret;
            r_cp0_bad_vaddr_wen <= w_detect && w_win.bad_vaddr_wen;
            r_cp0_bd            <= w_detect && w_win.bd;
            r_cp0_code          <= (w_detect && !w_win.is_eret) ? w_win.code : INT;
            r_cp0_epc           <= w_detect ? w_win.epc : '0;
            r_cp0_bad_vaddr     <= w_detect ? w_win.bad_vaddr : '0;
            if (w_detect) begin
                r_redirect_pc <= w_win.is_eret ? epc_address : EXC_VECTOR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_detect) begin
                    w_state_next = FLUSH;
                    w_cnt_next   = c_CNT_LOAD;
                end
            end
            FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_next = REDIRECT;
                end else begin
                    w_cnt_next = r_cnt - c_CNT_W'(1);
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign cp0_exp_en            = r_cp0_exp_en;
    assign cp0_exl_clean         = r_cp0_exl_clean;
    assign cp0_exp_bad_vaddr_wen = r_cp0_bad_vaddr_wen;
    assign cp0_exp_bd            = r_cp0_bd;
    assign cp0_exp_code          = r_cp0_code;
    assign cp0_exp_epc           = r_cp0_epc;
    assign cp0_exp_bad_vaddr     = r_cp0_bad_vaddr;
    assign redirect_valid        = (r_state == REDIRECT);
    assign redirect_pc           = r_redirect_pc;
    assign busy                  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_exception_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exception_unit
// Brief    : Self-checking bench for exception_unit (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exception_unit;

    localparam int          W   = 2;
    localparam int          F   = 2;
    localparam logic [31:0] VEC = 32'hbfc00380;

    logic              clk;
    logic              rst;
    logic [W-1:0]      inst_valid, iaddr_alignment_error, daddr_alignment_error;
    logic [W-1:0]      invalid_instruction, priv_instruction, syscall, break_;
    logic [W-1:0]      eret, overflow, mem_wen, is_branch_slot;
    logic [W-1:0][31:0] pc_address, mem_address;
    logic [31:0]       epc_address;
    logic              allow_interrupt;
    logic [7:0]        interrupt_flag;
    logic              is_inst;
    logic              exp_detect;
    logic [W-1:0]      exp_kill_mask;
    logic              cp0_exp_en, cp0_exl_clean, cp0_exp_bad_vaddr_wen, cp0_exp_bd;
    logic [4:0]        cp0_exp_code;
    logic [31:0]       cp0_exp_epc, cp0_exp_bad_vaddr;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              redirect_ready;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    exception_unit #(.ISSUE_WIDTH(W), .FLUSH_CYCLES(F), .EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid), .iaddr_alignment_error(iaddr_alignment_error),
        .daddr_alignment_error(daddr_alignment_error), .invalid_instruction(invalid_instruction),
        .priv_instruction(priv_instruction), .syscall(syscall), .break_(break_),
        .eret(eret), .overflow(overflow), .mem_wen(mem_wen), .is_branch_slot(is_branch_slot),
        .pc_address(pc_address), .mem_address(mem_address), .epc_address(epc_address),
        .allow_interrupt(allow_interrupt), .interrupt_flag(interrupt_flag), .is_inst(is_inst),
        .exp_detect(exp_detect), .exp_kill_mask(exp_kill_mask),
        .cp0_exp_en(cp0_exp_en), .cp0_exl_clean(cp0_exl_clean),
        .cp0_exp_bad_vaddr_wen(cp0_exp_bad_vaddr_wen), .cp0_exp_bd(cp0_exp_bd),
        .cp0_exp_code(cp0_exp_code), .cp0_exp_epc(cp0_exp_epc),
        .cp0_exp_bad_vaddr(cp0_exp_bad_vaddr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Cycle-count view: a detect opens a window; CP0 shows up one cycle later,
    // redirect is offered from 1+F cycles after detect until it is accepted.
    logic        m_busy;
    int          m_age;
    logic [7:0]  h0, h1;
    logic        m_en, m_exl, m_bd, m_badwen;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_bad, m_rpc;
    int          k, c, kc;
    logic [7:0]  pend;
    logic        e_det, e_rv, e_win1;
    logic [W-1:0] e_mask;

    // -1: nothing, 32: eret, otherwise the exception code
    function automatic int slot_code(input int s, input logic [7:0] p);
        if (!inst_valid[s]) return -1;
        if (s == 0 && is_inst && allow_interrupt && p != 8'd0) return 0;
        if (iaddr_alignment_error[s]) return 4;
        if (syscall[s])               return 8;
        if (break_[s])                return 9;
        if (invalid_instruction[s])   return 10;
        if (priv_instruction[s])      return 11;
        if (overflow[s])              return 12;
        if (eret[s])                  return 32;
        if (daddr_alignment_error[s]) return mem_wen[s] ? 5 : 4;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_age = 0; h0 = '0; h1 = '0;
            chk("rst_busy", busy, 0);
            chk("rst_redirect_valid", redirect_valid, 0);
            chk("rst_redirect_pc", redirect_pc, 0);
            chk("rst_cp0_en", cp0_exp_en, 0);
            chk("rst_cp0_exl", cp0_exl_clean, 0);
            chk("rst_cp0_code", cp0_exp_code, 0);
            chk("rst_cp0_epc", cp0_exp_epc, 0);
            chk("rst_cp0_bad", cp0_exp_bad_vaddr, 0);
        end else begin
`ifdef EXC_INT_SYNC_EN
            pend = h1;
`else
            pend = interrupt_flag;
`endif
            k = W; kc = -1;
            for (int s = 0; s < W; s++) begin
                c = slot_code(s, pend);
                if (k == W && c >= 0) begin k = s; kc = c; end
            end
            e_det = !m_busy && (k < W);
            for (int i = 0; i < W; i++) e_mask[i] = e_det && (i >= k);
            e_rv   = m_busy && (m_age >= 1 + F);
            e_win1 = m_busy && (m_age == 1);

            chk("exp_detect", exp_detect, e_det);
            chk("kill_mask", exp_kill_mask, e_mask);
            chk("busy", busy, m_busy);
            chk("redirect_valid", redirect_valid, e_rv);
            if (e_rv) chk("redirect_pc", redirect_pc, m_rpc);
            chk("cp0_exp_en", cp0_exp_en, e_win1 ? m_en : 1'b0);
            chk("cp0_exl_clean", cp0_exl_clean, e_win1 ? m_exl : 1'b0);
            chk("cp0_exp_code", cp0_exp_code, e_win1 ? m_code : 5'd0);
            chk("cp0_exp_epc", cp0_exp_epc, e_win1 ? m_epc : 32'd0);
            chk("cp0_exp_bd", cp0_exp_bd, e_win1 ? m_bd : 1'b0);
            chk("cp0_bad_vaddr", cp0_exp_bad_vaddr, e_win1 ? m_bad : 32'd0);
            chk("cp0_bad_wen", cp0_exp_bad_vaddr_wen, e_win1 ? m_badwen : 1'b0);

            if (!m_busy) begin
                if (e_det) begin
                    m_busy  = 1'b1;
                    m_age   = 1;
                    m_epc   = is_branch_slot[k] ? pc_address[k] - 32'd4 : pc_address[k];
                    m_bd    = is_branch_slot[k];
                    m_en    = (kc != 32);
                    m_exl   = (kc == 32);
                    m_code  = (kc == 32) ? 5'd0 : kc[4:0];
                    m_rpc   = (kc == 32) ? epc_address : VEC;
                    m_bad   = '0;
                    m_badwen = 1'b0;
                    if (kc == 4 && iaddr_alignment_error[k]) begin
                        m_bad = pc_address[k]; m_badwen = 1'b1;
                    end else if (kc == 4 || kc == 5) begin
                        m_bad = mem_address[k]; m_badwen = 1'b1;
                    end
                end
            end else begin
                if (e_rv && redirect_ready) m_busy = 1'b0;
                m_age++;
            end
            h1 = h0;
            h0 = interrupt_flag;
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        inst_valid = '0; iaddr_alignment_error = '0; daddr_alignment_error = '0;
        invalid_instruction = '0; priv_instruction = '0; syscall = '0; break_ = '0;
        eret = '0; overflow = '0; mem_wen = '0; is_branch_slot = '0;
        pc_address = '0; mem_address = '0;
        allow_interrupt = 1'b0; interrupt_flag = '0; is_inst = 1'b0;
    endtask

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin nc(); n++; end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clr(); epc_address = '0; redirect_ready = 1'b1;
        repeat (3) nc();
        chk("reset_busy", busy, 0);
        chk("reset_code", cp0_exp_code, 0);
        rst = 1'b0;
        repeat (3) nc();

        // slot 1 overflow, slot 0 clean
        inst_valid = 2'b11; pc_address[0] = 32'h80000ffc; pc_address[1] = 32'h80001000;
        overflow[1] = 1'b1;
        #1; chk("t1_detect", exp_detect, 1); chk("t1_mask", exp_kill_mask, 2'b10);
        nc(); clr(); #1;
        chk("t1_en", cp0_exp_en, 1); chk("t1_code", cp0_exp_code, 5'h0c);
        chk("t1_epc", cp0_exp_epc, 32'h80001000); chk("t1_bd", cp0_exp_bd, 0);
        nc(); #1; chk("t1_rv_t2", redirect_valid, 0); chk("t1_en_t2", cp0_exp_en, 0);
        nc(); #1; chk("t1_rv_t3", redirect_valid, 1); chk("t1_rpc", redirect_pc, VEC);
        nc(); #1; chk("t1_idle_t4", busy, 0);

        // slot 0 syscall beats slot 1 break
        inst_valid = 2'b11; syscall[0] = 1'b1; break_[1] = 1'b1;
        pc_address[0] = 32'h80000010; pc_address[1] = 32'h80000014;
        #1; chk("t2_mask", exp_kill_mask, 2'b11);
        nc(); clr(); #1; chk("t2_code", cp0_exp_code, 5'h08);
        wait_idle();

        // store misalignment in a delay slot
        inst_valid = 2'b01; daddr_alignment_error[0] = 1'b1; mem_wen[0] = 1'b1;
        is_branch_slot[0] = 1'b1; pc_address[0] = 32'h80000104; mem_address[0] = 32'h1002;
        nc(); clr(); #1;
        chk("t3_code", cp0_exp_code, 5'h05); chk("t3_epc", cp0_exp_epc, 32'h80000100);
        chk("t3_bd", cp0_exp_bd, 1); chk("t3_bad", cp0_exp_bad_vaddr, 32'h1002);
        chk("t3_bad_wen", cp0_exp_bad_vaddr_wen, 1);
        wait_idle();

        // eret: redirect to epc_address as sampled at detect
        inst_valid = 2'b01; eret[0] = 1'b1; pc_address[0] = 32'h80000300;
        epc_address = 32'h80002000;
        nc(); clr(); epc_address = 32'h12345678; #1;
        chk("t4_exl", cp0_exl_clean, 1); chk("t4_en", cp0_exp_en, 0);
        chk("t4_code", cp0_exp_code, 0);
        nc(); nc(); #1; chk("t4_rv", redirect_valid, 1);
        chk("t4_rpc", redirect_pc, 32'h80002000);
        wait_idle();

        // wrap-around delay slot on slot 1, slot 0 flags ignored when invalid
        inst_valid = 2'b10; syscall[0] = 1'b1; break_[1] = 1'b1;
        is_branch_slot[1] = 1'b1; pc_address[1] = 32'h0;
        #1; chk("t5_mask", exp_kill_mask, 2'b10);
        nc(); clr(); #1;
        chk("t5_code", cp0_exp_code, 5'h09); chk("t5_epc", cp0_exp_epc, 32'hfffffffc);
        wait_idle();

        // back-pressure on redirect; a syscall while busy is dropped
        redirect_ready = 1'b0;
        inst_valid = 2'b01; syscall[0] = 1'b1; pc_address[0] = 32'h80000400;
        nc(); clr();
        begin
            int n = 0;
            while (!redirect_valid && n < 10) begin nc(); n++; end
        end
        chk("t6_rv_rise", redirect_valid, 1);
        for (int i = 0; i < 5; i++) begin
            inst_valid = 2'b01; syscall[0] = 1'b1;
            #1;
            chk("t6_busy_detect", exp_detect, 0); chk("t6_busy_mask", exp_kill_mask, 0);
            chk("t6_rv_hold", redirect_valid, 1); chk("t6_rpc_hold", redirect_pc, VEC);
            nc();
        end
        clr(); redirect_ready = 1'b1;
        nc(); #1; chk("t6_idle", busy, 0);
        repeat (2) nc();

        // interrupt on slot 0
        inst_valid = 2'b01; is_inst = 1'b1; allow_interrupt = 1'b1;
        interrupt_flag = 8'h04; pc_address[0] = 32'h80000200;
`ifdef EXC_INT_SYNC_EN
        #1; chk("t7_detect_early", exp_detect, 0);
        repeat (2) nc();
`endif
        #1; chk("t7_detect", exp_detect, 1);
        nc(); clr(); #1;
        chk("t7_en", cp0_exp_en, 1); chk("t7_code", cp0_exp_code, 5'h00);
        chk("t7_epc", cp0_exp_epc, 32'h80000200);
        wait_idle();
        repeat (3) nc();

        // reset during FLUSH aborts without redirect
        inst_valid = 2'b01; syscall[0] = 1'b1; pc_address[0] = 32'h80000500;
        nc(); clr(); #1;
        chk("t8_busy_flush", busy, 1);
        rst = 1'b1; #1;
        chk("t8_busy_rst", busy, 0); chk("t8_en_rst", cp0_exp_en, 0);
        nc(); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nc(); chk("t8_no_redirect", redirect_valid, 0);
        end

        repeat (2) nc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
